// File: rtl/gpr_wb_arbiter.sv
// Write-back arbiter for the GPR file.
// Arbitrates execute and load results onto the single register-file write port
// (round-robin on contention), registers the winning write for one cycle, and keeps
// a per-register pending scoreboard that decode uses to stall on WAW hazards.
module gpr_wb_arbiter #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            exu_valid,
    input  logic [4:0]      exu_rd,
    input  logic [XLEN-1:0] exu_data,
    output logic            exu_ready,
    input  logic            lsu_valid,
    input  logic [4:0]      lsu_rd,
    input  logic [XLEN-1:0] lsu_data,
    output logic            lsu_ready,
    input  logic            issue_valid,
    input  logic [4:0]      issue_rd,
    output logic            issue_ready,
    output logic [31:0]     busy,
    output logic            RegWEn,
    output logic [4:0]      addr_towrite,
    output logic [XLEN-1:0] data_towrite,
    output logic [31:0]     wb_count
);

    // prio_lsu_q = 1 means lsu wins the next contention (exu was granted last)
    logic            prio_lsu_q, prio_lsu_d;
    logic            grant_exu, grant_lsu;
    logic            wen_q, wen_d;
    logic [4:0]      addr_q, addr_d;
    logic [XLEN-1:0] data_q, data_d;
    logic [31:0]     busy_q, busy_d;
    logic [31:0]     count_q, count_d;
    logic            issue_accept;

    // Grant decision: a lone requester always wins, contention goes to the favoured side
    always_comb begin
        grant_exu = 1'b0;
        grant_lsu = 1'b0;
        if (!rst) begin
            if (exu_valid && lsu_valid) begin
                grant_lsu = prio_lsu_q;
                grant_exu = !prio_lsu_q;
            end else begin
                grant_exu = exu_valid;
                grant_lsu = lsu_valid;
            end
        end
    end

    assign exu_ready    = grant_exu;
    assign lsu_ready    = grant_lsu;
    assign issue_ready  = !rst && ((issue_rd == 5'd0) || !busy_q[issue_rd]);
    assign issue_accept = issue_valid && issue_ready && (issue_rd != 5'd0);

    // Next-state: pointer, registered write, scoreboard and commit counter
    always_comb begin
        prio_lsu_d = prio_lsu_q;
        wen_d      = 1'b0;
        addr_d     = addr_q;
        data_d     = data_q;
        busy_d     = busy_q;
        count_d    = count_q;

        if (grant_exu) begin
            prio_lsu_d = 1'b1;
            if (exu_rd != 5'd0) begin
                wen_d  = 1'b1;
                addr_d = exu_rd;
                data_d = exu_data;
            end
        end else if (grant_lsu) begin
            prio_lsu_d = 1'b0;
            if (lsu_rd != 5'd0) begin
                wen_d  = 1'b1;
                addr_d = lsu_rd;
                data_d = lsu_data;
            end
        end

        // Clear first so a same-index set on this edge wins
        if (wen_q) begin
            busy_d[addr_q] = 1'b0;
            count_d        = count_q + 32'd1;
        end
        if (issue_accept) begin
            busy_d[issue_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // State registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prio_lsu_q <= 1'b0;
            wen_q      <= 1'b0;
            addr_q     <= 5'd0;
            data_q     <= '0;
            busy_q     <= 32'd0;
            count_q    <= 32'd0;
        end else begin
            prio_lsu_q <= prio_lsu_d;
            wen_q      <= wen_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            busy_q     <= busy_d;
            count_q    <= count_d;
        end
    end

    assign busy         = busy_q;
    assign RegWEn       = wen_q;
    assign addr_towrite = addr_q;
    assign data_towrite = data_q;
    assign wb_count     = count_q;

endmodule

// File: doc/gpr_wb_arbiter.md
GPR_WB_ARBITER -- requirements
Module: gpr_wb_arbiter

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning the data width of write-back and register-file write data.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset: asynchronous and active-high.
REQ-004 SHALL have port exu_valid, input, 1, meaning the execute unit presents a write-back request.
REQ-005 SHALL have port exu_rd, input, 5, meaning the execute destination register index.
REQ-006 SHALL have port exu_data, input, XLEN, meaning the execute result.
REQ-007 SHALL have port exu_ready, output, 1, meaning the execute request is accepted this cycle.
REQ-008 SHALL have port lsu_valid, input, 1, meaning the load/store unit presents a load write-back request.
REQ-009 SHALL have port lsu_rd, input, 5, meaning the load destination register index.
REQ-010 SHALL have port lsu_data, input, XLEN, meaning the load result.
REQ-011 SHALL have port lsu_ready, output, 1, meaning the load request is accepted this cycle.
REQ-012 SHALL have port issue_valid, input, 1, meaning decode marks a destination register as pending.
REQ-013 SHALL have port issue_rd, input, 5, meaning the destination register being marked.
REQ-014 SHALL have port issue_ready, output, 1, meaning the mark is accepted; low on a WAW hazard.
REQ-015 SHALL have port busy, output, 32, meaning the scoreboard, one pending bit per GPR.
REQ-016 SHALL have port RegWEn, output, 1, meaning the register-file write enable.
REQ-017 SHALL have port addr_towrite, output, 5, meaning the register-file write index.
REQ-018 SHALL have port data_towrite, output, XLEN, meaning the register-file write data.
REQ-019 SHALL have port wb_count, output, 32, meaning the number of committed non-x0 writes.

Function
REQ-020 SHALL accept a request on the edge where valid and ready are both high; ready depends combinationally on the valids and the arbiter state only, never on data.
REQ-021 SHALL grant at most one source per cycle; the output path never back-pressures, so a lone valid source is always granted the same cycle.
REQ-022 SHALL resolve simultaneous exu_valid and lsu_valid by round-robin: grant the source not granted most recently; the priority pointer updates only on an accepted transfer.
REQ-023 SHALL register the granted request so that RegWEn, addr_towrite and data_towrite appear exactly one cycle after acceptance; throughput is one write per cycle.
REQ-024 SHALL accept requests with rd=0 (handshake completes) but drive RegWEn=0 for them in the following cycle, and not count them.
REQ-025 SHALL hold addr_towrite and data_towrite at their last values when RegWEn=0.
REQ-026 SHALL drive issue_ready = (issue_rd==0) or not busy[issue_rd].
REQ-027 SHALL set busy[issue_rd] on an accepted issue with issue_rd!=0; busy[0] SHALL be constant 0.
REQ-028 SHALL clear busy[addr_towrite] on the edge ending a cycle where RegWEn=1.
REQ-029 SHALL let the set take priority when a set and a clear target the same index on the same edge, so the bit remains 1.
REQ-030 SHALL increment wb_count by one on each edge ending a cycle where RegWEn=1, with modulo 2^32 wrap to 0.

Reset
REQ-031 SHALL, while rst=1 and independent of clk, force RegWEn=0, addr_towrite=0, data_towrite=0, busy=0, wb_count=0 and the round-robin pointer to favour exu.
REQ-032 SHALL discard any transfer registered but not yet written when reset asserts mid-operation; no write appears after deassertion.
REQ-033 SHALL drive exu_ready, lsu_ready and issue_ready low while rst=1.

Verification
REQ-034 Scenario: exu_valid=1, rd=5, data=0xDEADBEEF for one cycle -> exu_ready=1 that cycle; next cycle RegWEn=1, addr_towrite=5, data_towrite=0xDEADBEEF; wb_count=1.
REQ-035 Scenario: first contention after reset, both valid, exu rd=3/0x11, lsu rd=4/0x22, held for 2 cycles -> exu granted first, lsu second; writes rd3 then rd4 on consecutive cycles.
REQ-036 Scenario: lsu_valid, rd=0, data=0x1234 -> lsu_ready=1; next cycle RegWEn=0; wb_count unchanged.
REQ-037 Scenario: issue rd=7, then issue rd=7 again -> busy[7]=1 and issue_ready=0 for the second; after exu write-back of rd7, busy[7]=0 and issue_ready=1.
REQ-038 Scenario: RegWEn=1 for rd=9 on the same edge as an accepted issue of rd=9 -> busy[9]=1 after the edge.
REQ-039 Scenario: wb_count preset via 2^32-1 writes (or forced) plus one write -> wb_count=0; then assert rst mid-transfer -> RegWEn=0 immediately, busy=0, no write after release.
